// File: rtl/shifter_pkg.sv
// Shared types and helpers for the multi-cycle shifter.
package shifter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Width of a counter that must hold every value 0..2n inclusive.
   function automatic int rem_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP bits, zero-filled.
// With SHIFTER_STICKY_EN it also reports the OR of the bits pushed out.
module shift_step
   import shifter_pkg::*;
#(
   parameter int W  = 16,
   parameter int KW = 5
) (
   input  logic [W-1:0]  val,
   input  logic [KW-1:0] k,
   input  logic          dir,
`ifdef SHIFTER_STICKY_EN
   output logic          lost,
`endif
   output logic [W-1:0]  res
);

   logic [W-1:0] ones;
   assign ones = '1;

   always_comb begin
      // NOTE: every output gets a default first so no path through the block can infer a latch.
      res = val >> k;
`ifdef SHIFTER_STICKY_EN
      // Bits leaving the low end on a right shift, the high end on a left shift.
      lost = |(val & ~(ones << k));
`endif
      if (dir == DIR_LEFT) begin
         res = val << k;
`ifdef SHIFTER_STICKY_EN
         lost = |(val & ~(ones >> k));
`endif
      end
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle logical shifter of a 2N-bit operand, STEP bits per cycle, start/done handshake.
// Optional sticky output (OR of all shifted-out bits) is built when SHIFTER_STICKY_EN is defined.
module shift_unit_seq
   import shifter_pkg::*;
#(
   parameter int N    = 8,
   parameter int STEP = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           dir,
   input  logic [N-1:0]   amt,
   input  logic [2*N-1:0] din,
   output logic           busy,
   output logic           done,
`ifdef SHIFTER_STICKY_EN
   output logic           sticky,
`endif
   output logic [2*N-1:0] dout
);

   localparam int W  = 2 * N;
   localparam int CW = rem_width(N);

   state_e         state, state_nxt;
   logic [W-1:0]   work;
   logic           work_dir;
   logic [CW-1:0]  rem;
   logic [CW-1:0]  rem_init;
   logic [CW-1:0]  k;
   logic           last_step;
   logic [W-1:0]   step_res;
`ifdef SHIFTER_STICKY_EN
   logic           step_lost;
`endif

   // Amounts of 2N or more saturate: the operand is shifted out completely.
   assign rem_init  = ({1'b0, amt} >= (N + 1)'(W)) ? CW'(W) : CW'(amt);
   assign k         = (rem < CW'(STEP)) ? rem : CW'(STEP);
   assign last_step = (rem == k);

   shift_step #(.W(W), .KW(CW)) u_step (
      .val (work),
      .k   (k),
      .dir (work_dir),
`ifdef SHIFTER_STICKY_EN
      .lost(step_lost),
`endif
      .res (step_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (rem_init == '0) ? DONE : SHIFT;
         SHIFT:   if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // dout is loaded on the edge into DONE so it is already valid while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work     <= '0;
         work_dir <= DIR_RIGHT;
         rem      <= '0;
         dout     <= '0;
`ifdef SHIFTER_STICKY_EN
         sticky   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (start) begin
               work     <= din;
               work_dir <= dir;
               rem      <= rem_init;
`ifdef SHIFTER_STICKY_EN
               sticky   <= 1'b0;
`endif
               if (rem_init == '0) dout <= din;
            end
            SHIFT: begin
               work <= step_res;
               rem  <= rem - k;
`ifdef SHIFTER_STICKY_EN
               sticky <= sticky | step_lost;
`endif
               if (last_step) dout <= step_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq: STEP=1 and STEP=4 instances side by side.
// Sticky checks are compiled in only when SHIFTER_STICKY_EN is defined.
module tb_shift_unit_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start4 = 1'b0;
   logic        dir_i = 1'b0;
   logic [7:0]  amt_i = '0;
   logic [15:0] din_i = '0;
   logic        busy1, busy4, done1, done4;
   logic [15:0] dout1, dout4;
`ifdef SHIFTER_STICKY_EN
   logic        sticky1, sticky4;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   shift_unit_seq #(.N(8), .STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dir(dir_i), .amt(amt_i), .din(din_i),
      .busy(busy1), .done(done1),
`ifdef SHIFTER_STICKY_EN
      .sticky(sticky1),
`endif
      .dout(dout1)
   );

   shift_unit_seq #(.N(8), .STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .dir(dir_i), .amt(amt_i), .din(din_i),
      .busy(busy4), .done(done4),
`ifdef SHIFTER_STICKY_EN
      .sticky(sticky4),
`endif
      .dout(dout4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cur_done(input int sel);
      return (sel == 4) ? done4 : done1;
   endfunction

   function automatic logic [15:0] cur_dout(input int sel);
      return (sel == 4) ? dout4 : dout1;
   endfunction

`ifdef SHIFTER_STICKY_EN
   function automatic logic cur_sticky(input int sel);
      return (sel == 4) ? sticky4 : sticky1;
   endfunction
`endif

   // Issue one operation and follow it to done; latency counts clock edges from the start edge.
   task automatic do_op(input int sel, input string tag, input logic [15:0] d, input logic [7:0] a,
                        input logic dr, input logic [15:0] exp_dout, input logic exp_sticky,
                        input int exp_lat);
      logic [15:0] prev;
      bit          stable;
      bit          seen;
      int          lat;
      @(negedge clk);
      prev  = cur_dout(sel);
      din_i = d;
      amt_i = a;
      dir_i = dr;
      if (sel == 4) start4 = 1'b1;
      else          start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start4 = 1'b0;
      din_i  = ~d;
      amt_i  = 8'd0;
      dir_i  = ~dr;
      lat    = 1;
      stable = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cur_done(sel)) begin
            seen = 1'b1;
            break;
         end
         if (cur_dout(sel) !== prev) stable = 1'b0;
         @(posedge clk);
         lat++;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         check({tag, "_dout"}, 32'(cur_dout(sel)), 32'(exp_dout));
         check({tag, "_dout_hold"}, 32'(stable), 32'd1);
`ifdef SHIFTER_STICKY_EN
         check({tag, "_sticky"}, 32'(cur_sticky(sel)), 32'(exp_sticky));
`else
         if (exp_sticky === 1'bx) check({tag, "_sticky_arg"}, 32'(exp_sticky), 32'd0);
`endif
      end
   endtask

   initial begin
      int  ndone;
      int  first_lat;
      bit  busy_after;

      // Reset state
      #1;
      check("rst_busy1", 32'(busy1), 32'd0);
      check("rst_done1", 32'(done1), 32'd0);
      check("rst_dout1", 32'(dout1), 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_done4", 32'(done4), 32'd0);
      check("rst_dout4", 32'(dout4), 32'd0);
`ifdef SHIFTER_STICKY_EN
      check("rst_sticky1", 32'(sticky1), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Right shift by 4, one bit per cycle; low nibble F is lost.
      do_op(1, "s1_r4", 16'hF00F, 8'd4, 1'b0, 16'h0F00, 1'b1, 5);
      // Left shift by 9, four bits per cycle; bit 7 of the operand falls off the top.
      do_op(4, "s4_l9", 16'h00FF, 8'd9, 1'b1, 16'hFE00, 1'b1, 4);
      // Zero amount passes the operand through on the next cycle.
      do_op(1, "s1_a0", 16'h1234, 8'd0, 1'b0, 16'h1234, 1'b0, 1);
      // Saturating amount: clamped to 16, ceil(16/4)+1 = 5 cycles, result zero.
      do_op(4, "s4_sat", 16'h1234, 8'd200, 1'b0, 16'h0000, 1'b1, 5);

      // start pulsed during SHIFT and during DONE must be ignored.
      @(negedge clk);
      din_i  = 16'hA5A5;
      amt_i  = 8'd3;
      dir_i  = 1'b1;
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      ndone      = 0;
      first_lat  = -1;
      busy_after = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            din_i  = 16'hFFFF;
            amt_i  = 8'd0;
            start1 = 1'b1;
         end
         if (done1) begin
            ndone++;
            if (first_lat < 0) begin
               first_lat = i + 1;
               din_i  = 16'hFFFF;
               amt_i  = 8'd0;
               start1 = 1'b1;
            end
         end else if (first_lat >= 0 && i == first_lat && busy1) begin
            busy_after = 1'b1;
         end
         @(posedge clk);
         #1 start1 = 1'b0;
      end
      check("ign_done_count", 32'(ndone), 32'd1);
      check("ign_latency", 32'(first_lat), 32'd4);
      check("ign_busy_after_done", 32'(busy_after), 32'd0);
      check("ign_dout", 32'(dout1), 32'h2D28);
`ifdef SHIFTER_STICKY_EN
      check("ign_sticky", 32'(sticky1), 32'd1);
`endif

      // Back-to-back on STEP=4: each start lands on the cycle after the previous done.
      do_op(4, "b2b_0", 16'hC3C3, 8'd5, 1'b0, 16'h061E, 1'b1, 3);
      do_op(4, "b2b_1", 16'h0F0F, 8'd16, 1'b1, 16'h0000, 1'b1, 5);
      do_op(4, "b2b_2", 16'h1234, 8'd2, 1'b1, 16'h48D0, 1'b0, 2);

      // Asynchronous abort on the second SHIFT cycle of an 8-bit shift.
      @(negedge clk);
      din_i  = 16'hFFFF;
      amt_i  = 8'd8;
      dir_i  = 1'b0;
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy1", 32'(busy1), 32'd0);
      check("abort_done1", 32'(done1), 32'd0);
      check("abort_dout1", 32'(dout1), 32'd0);
      check("abort_dout4", 32'(dout4), 32'd0);
`ifdef SHIFTER_STICKY_EN
      check("abort_sticky1", 32'(sticky1), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1, "post_abort", 16'h8001, 8'd1, 1'b0, 16'h4000, 1'b1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
